// File: rtl/odd_issue_pkg.sv
// Shared definitions for the odd-pipe issue stage: packed-stage field
// offsets, unit encodings, the issued-instruction record and its bubble.
package odd_issue_pkg;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned RADDR_W  = 7;
    localparam int unsigned PACK_W   = 143;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned ID_W     = 7;
    localparam int unsigned UNIT_W   = 3;
    localparam int unsigned LAT_W    = 4;
    localparam int unsigned IMM7_W   = 7;
    localparam int unsigned IMM10_W  = 10;
    localparam int unsigned IMM16_W  = 16;
    localparam int unsigned IMM18_W  = 18;
    localparam int unsigned PC_W     = 10;
    localparam int unsigned NUM_FWD  = 6;   // forwarding stages 2..7

    // Field offsets inside a packed odd-pipe stage word
    localparam int unsigned UNIT_LSB   = 0;
    localparam int unsigned RESULT_LSB = 3;
    localparam int unsigned DST_LSB    = 131;
    localparam int unsigned LAT_LSB    = 138;
    localparam int unsigned WR_BIT     = 142;

    // Odd-pipe unit identifiers
    localparam logic [UNIT_W-1:0] UNIT_PERM   = 3'b101;
    localparam logic [UNIT_W-1:0] UNIT_LS     = 3'b110;
    localparam logic [UNIT_W-1:0] UNIT_BRANCH = 3'b111;

    typedef logic [PACK_W-1:0] pack_t;

    // Instruction record held in the stage-1 output register
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ID_W-1:0]    instr_id;
        logic [UNIT_W-1:0]  unit_id;
        logic [LAT_W-1:0]   latency;
        logic               reg_wr;
        logic [RADDR_W-1:0] reg_dst;
        logic [IMM7_W-1:0]  imme7;
        logic [IMM10_W-1:0] imme10;
        logic [IMM16_W-1:0] imme16;
        logic [IMM18_W-1:0] imme18;
        logic [PC_W-1:0]    pc;
        logic [DATA_W-1:0]  ra_data;
        logic [DATA_W-1:0]  rb_data;
        logic [DATA_W-1:0]  rc_data;
    } issue_word_t;

    localparam issue_word_t ISSUE_BUBBLE = '0;

    function automatic logic pack_wr(input pack_t p);
        return p[WR_BIT];
    endfunction

    function automatic logic [RADDR_W-1:0] pack_dst(input pack_t p);
        return p[DST_LSB +: RADDR_W];
    endfunction

    function automatic logic [LAT_W-1:0] pack_lat(input pack_t p);
        return p[LAT_LSB +: LAT_W];
    endfunction

    function automatic logic [DATA_W-1:0] pack_result(input pack_t p);
        return p[RESULT_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/odd_operand_sel.sv
// Per-source operand resolution: finds the youngest in-flight producer of
// one register, flags a RAW hazard if it cannot forward, and muxes data.
module odd_operand_sel
    import odd_issue_pkg::*;
(
    input  logic [RADDR_W-1:0]             addr,
    input  logic                           used,
    input  logic                           s1_wr,
    input  logic [RADDR_W-1:0]             s1_dst,
    input  logic [NUM_FWD-1:0][PACK_W-1:0] fwd,
    input  logic [RADDR_W-1:0]             wb_addr,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           wb_en,
    input  logic [DATA_W-1:0]              rf_data,
    output logic                           hazard_c,
    output logic [DATA_W-1:0]              data_c
);

    logic unused_unit_bits;

    // Priority from oldest to youngest so the youngest match overrides
    always_comb begin
        hazard_c = 1'b0;
        data_c   = rf_data;
        if (wb_en && (wb_addr == addr)) begin
            data_c = wb_data;
        end
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (pack_wr(fwd[i]) && (pack_dst(fwd[i]) == addr)) begin
                data_c   = pack_result(fwd[i]);
                // stage k = i+2 forwards only once it is past the producer latency
                hazard_c = used && ({1'b0, pack_lat(fwd[i])} >= 5'(i + 2));
            end
        end
        // Stage 1 never forwards: a match there always stalls
        if (s1_wr && (s1_dst == addr)) begin
            hazard_c = used;
        end
    end

    // Unit id of forwarding stages does not affect operand selection
    always_comb begin
        unused_unit_bits = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            unused_unit_bits = unused_unit_bits ^ (^fwd[i][UNIT_LSB +: UNIT_W]);
        end
    end

endmodule

// File: rtl/odd_issue_stage.sv
// Odd-pipe register-fetch/issue stage: resolves operands, stalls decode on
// unresolvable RAW hazards and loads the stage-1 register with an
// instruction or a bubble.
// Optional macro ODD_ISSUE_PERF_EN adds saturating stall/flush counters.
module odd_issue_stage
    import odd_issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [ID_W-1:0]     in_instr_id,
    input  logic [UNIT_W-1:0]   in_unit_id,
    input  logic [LAT_W-1:0]    in_latency,
    input  logic                in_reg_wr,
    input  logic [RADDR_W-1:0]  in_reg_dst,
    input  logic [IMM7_W-1:0]   in_imme7,
    input  logic [IMM10_W-1:0]  in_imme10,
    input  logic [IMM16_W-1:0]  in_imme16,
    input  logic [IMM18_W-1:0]  in_imme18,
    input  logic [PC_W-1:0]     in_pc,
    input  logic [RADDR_W-1:0]  in_ra_addr,
    input  logic [RADDR_W-1:0]  in_rb_addr,
    input  logic [RADDR_W-1:0]  in_rc_addr,
    input  logic                in_ra_use,
    input  logic                in_rb_use,
    input  logic                in_rc_use,
    input  logic [DATA_W-1:0]   rf_ra_data,
    input  logic [DATA_W-1:0]   rf_rb_data,
    input  logic [DATA_W-1:0]   rf_rc_data,
    input  logic [PACK_W-1:0]   fwd_stage2,
    input  logic [PACK_W-1:0]   fwd_stage3,
    input  logic [PACK_W-1:0]   fwd_stage4,
    input  logic [PACK_W-1:0]   fwd_stage5,
    input  logic [PACK_W-1:0]   fwd_stage6,
    input  logic [PACK_W-1:0]   fwd_stage7,
    input  logic [RADDR_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                wb_en,
    input  logic                flush,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ID_W-1:0]     out_instr_id,
    output logic [UNIT_W-1:0]   out_unit_id,
    output logic [LAT_W-1:0]    out_latency,
    output logic                out_reg_wr,
    output logic [RADDR_W-1:0]  out_reg_dst,
    output logic [IMM7_W-1:0]   out_imme7,
    output logic [IMM10_W-1:0]  out_imme10,
    output logic [IMM16_W-1:0]  out_imme16,
    output logic [IMM18_W-1:0]  out_imme18,
    output logic [PC_W-1:0]     out_pc,
    output logic [DATA_W-1:0]   out_ra_data,
    output logic [DATA_W-1:0]   out_rb_data,
    output logic [DATA_W-1:0]   out_rc_data
`ifdef ODD_ISSUE_PERF_EN
    ,
    output logic [31:0]         stall_count,
    output logic [15:0]         flush_count
`endif
);

    logic [NUM_FWD-1:0][PACK_W-1:0] fwd_bus;
    issue_word_t                    s1_q;
    issue_word_t                    s1_d;
    logic                           ra_hazard_c;
    logic                           rb_hazard_c;
    logic                           rc_hazard_c;
    logic [DATA_W-1:0]              ra_data_c;
    logic [DATA_W-1:0]              rb_data_c;
    logic [DATA_W-1:0]              rc_data_c;
    logic                           hazard_c;
    logic                           transfer_c;

    // Index 0 is stage 2 (youngest forwarding stage)
    assign fwd_bus = {fwd_stage7, fwd_stage6, fwd_stage5,
                      fwd_stage4, fwd_stage3, fwd_stage2};

    odd_operand_sel u_sel_ra (
        .addr     (in_ra_addr),
        .used     (in_ra_use),
        .s1_wr    (s1_q.reg_wr),
        .s1_dst   (s1_q.reg_dst),
        .fwd      (fwd_bus),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_en    (wb_en),
        .rf_data  (rf_ra_data),
        .hazard_c (ra_hazard_c),
        .data_c   (ra_data_c)
    );

    odd_operand_sel u_sel_rb (
        .addr     (in_rb_addr),
        .used     (in_rb_use),
        .s1_wr    (s1_q.reg_wr),
        .s1_dst   (s1_q.reg_dst),
        .fwd      (fwd_bus),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_en    (wb_en),
        .rf_data  (rf_rb_data),
        .hazard_c (rb_hazard_c),
        .data_c   (rb_data_c)
    );

    odd_operand_sel u_sel_rc (
        .addr     (in_rc_addr),
        .used     (in_rc_use),
        .s1_wr    (s1_q.reg_wr),
        .s1_dst   (s1_q.reg_dst),
        .fwd      (fwd_bus),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_en    (wb_en),
        .rf_data  (rf_rc_data),
        .hazard_c (rc_hazard_c),
        .data_c   (rc_data_c)
    );

    assign hazard_c   = in_valid && (ra_hazard_c || rb_hazard_c || rc_hazard_c);
    assign in_ready   = !hazard_c;
    assign transfer_c = in_valid && in_ready;

    // Next stage-1 content: the accepted instruction, else a bubble (also on flush)
    always_comb begin
        s1_d = ISSUE_BUBBLE;
        if (transfer_c && !flush) begin
            s1_d.instr    = in_instr;
            s1_d.instr_id = in_instr_id;
            s1_d.unit_id  = in_unit_id;
            s1_d.latency  = in_latency;
            s1_d.reg_wr   = in_reg_wr;
            s1_d.reg_dst  = in_reg_dst;
            s1_d.imme7    = in_imme7;
            s1_d.imme10   = in_imme10;
            s1_d.imme16   = in_imme16;
            s1_d.imme18   = in_imme18;
            s1_d.pc       = in_pc;
            s1_d.ra_data  = ra_data_c;
            s1_d.rb_data  = rb_data_c;
            s1_d.rc_data  = rc_data_c;
        end
    end

    // Stage-1 output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= ISSUE_BUBBLE;
        end else begin
            s1_q <= s1_d;
        end
    end

    assign out_instr    = s1_q.instr;
    assign out_instr_id = s1_q.instr_id;
    assign out_unit_id  = s1_q.unit_id;
    assign out_latency  = s1_q.latency;
    assign out_reg_wr   = s1_q.reg_wr;
    assign out_reg_dst  = s1_q.reg_dst;
    assign out_imme7    = s1_q.imme7;
    assign out_imme10   = s1_q.imme10;
    assign out_imme16   = s1_q.imme16;
    assign out_imme18   = s1_q.imme18;
    assign out_pc       = s1_q.pc;
    assign out_ra_data  = s1_q.ra_data;
    assign out_rb_data  = s1_q.rb_data;
    assign out_rc_data  = s1_q.rc_data;

`ifdef ODD_ISSUE_PERF_EN
    // Saturating counters of stalled decode cycles and flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hazard_c && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_odd_issue_stage.sv
// Randomized self-checking bench for odd_issue_stage with a reference model.
// Define ODD_ISSUE_PERF_EN to also check the stall/flush counters.
module tb_odd_issue_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [6:0]   in_instr_id;
    logic [2:0]   in_unit_id;
    logic [3:0]   in_latency;
    logic         in_reg_wr;
    logic [6:0]   in_reg_dst;
    logic [6:0]   in_imme7;
    logic [9:0]   in_imme10;
    logic [15:0]  in_imme16;
    logic [17:0]  in_imme18;
    logic [9:0]   in_pc;
    logic [6:0]   in_ra_addr, in_rb_addr, in_rc_addr;
    logic         in_ra_use, in_rb_use, in_rc_use;
    logic [127:0] rf_ra_data, rf_rb_data, rf_rc_data;
    logic [142:0] fwd_stage2, fwd_stage3, fwd_stage4, fwd_stage5, fwd_stage6, fwd_stage7;
    logic [6:0]   wb_addr;
    logic [127:0] wb_data;
    logic         wb_en;
    logic         flush;
    logic [31:0]  out_instr;
    logic [6:0]   out_instr_id;
    logic [2:0]   out_unit_id;
    logic [3:0]   out_latency;
    logic         out_reg_wr;
    logic [6:0]   out_reg_dst;
    logic [6:0]   out_imme7;
    logic [9:0]   out_imme10;
    logic [15:0]  out_imme16;
    logic [17:0]  out_imme18;
    logic [9:0]   out_pc;
    logic [127:0] out_ra_data, out_rb_data, out_rc_data;
`ifdef ODD_ISSUE_PERF_EN
    logic [31:0]  stall_count;
    logic [15:0]  flush_count;
`endif

    // Producer descriptions for stages 2..7 (index = stage number)
    logic         f_wr  [8];
    logic [6:0]   f_dst [8];
    logic [3:0]   f_lat [8];
    logic [127:0] f_res [8];
    logic [2:0]   f_unit[8];

    // Expected stage-1 register
    logic [53:0]  e_ctl;   // {instr, id, unit, lat, wr, dst}
    logic [60:0]  e_imm;   // {imme7, imme10, imme16, imme18, pc}
    logic [127:0] e_ra, e_rb, e_rc;
    logic [31:0]  e_stall;
    logic [15:0]  e_flush;

    int checks = 0;
    int errors = 0;

    odd_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_instr_id(in_instr_id), .in_unit_id(in_unit_id),
        .in_latency(in_latency), .in_reg_wr(in_reg_wr), .in_reg_dst(in_reg_dst),
        .in_imme7(in_imme7), .in_imme10(in_imme10), .in_imme16(in_imme16),
        .in_imme18(in_imme18), .in_pc(in_pc),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_ra_use(in_ra_use), .in_rb_use(in_rb_use), .in_rc_use(in_rc_use),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
        .fwd_stage2(fwd_stage2), .fwd_stage3(fwd_stage3), .fwd_stage4(fwd_stage4),
        .fwd_stage5(fwd_stage5), .fwd_stage6(fwd_stage6), .fwd_stage7(fwd_stage7),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en), .flush(flush),
        .out_instr(out_instr), .out_instr_id(out_instr_id), .out_unit_id(out_unit_id),
        .out_latency(out_latency), .out_reg_wr(out_reg_wr), .out_reg_dst(out_reg_dst),
        .out_imme7(out_imme7), .out_imme10(out_imme10), .out_imme16(out_imme16),
        .out_imme18(out_imme18), .out_pc(out_pc),
        .out_ra_data(out_ra_data), .out_rb_data(out_rb_data), .out_rc_data(out_rc_data)
`ifdef ODD_ISSUE_PERF_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [142:0] mk_pack(input int k);
        return {f_wr[k], f_lat[k], f_dst[k], f_res[k], f_unit[k]};
    endfunction

    // Reference for one source: youngest producer decides stall, data by priority
    task automatic model_src(input logic [6:0] addr, input logic used, input logic [127:0] rf,
                             output logic hz, output logic [127:0] dat);
        bit found;
        bit dfound;
        hz     = 1'b0;
        found  = 1'b0;
        dfound = 1'b0;
        dat    = rf;
        if (e_ctl[7] && (e_ctl[6:0] == addr)) begin
            found = 1'b1;
            hz    = used;
        end
        for (int k = 2; k <= 7; k++) begin
            if (f_wr[k] && (f_dst[k] == addr)) begin
                if (!found) begin
                    found = 1'b1;
                    hz    = used && !(k > int'(f_lat[k]));
                end
                if (!dfound) begin
                    dfound = 1'b1;
                    dat    = f_res[k];
                end
            end
        end
        if (!dfound && wb_en && (wb_addr == addr)) dat = wb_data;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ctl"}, 128'({out_instr, out_instr_id, out_unit_id, out_latency,
                                   out_reg_wr, out_reg_dst}), 128'(e_ctl));
        check({tag, "_imm"}, 128'({out_imme7, out_imme10, out_imme16, out_imme18, out_pc}),
              128'(e_imm));
        check({tag, "_ra"}, out_ra_data, e_ra);
        check({tag, "_rb"}, out_rb_data, e_rb);
        check({tag, "_rc"}, out_rc_data, e_rc);
`ifdef ODD_ISSUE_PERF_EN
        check({tag, "_stall_cnt"}, 128'(stall_count), 128'(e_stall));
        check({tag, "_flush_cnt"}, 128'(flush_count), 128'(e_flush));
`endif
    endtask

    task automatic model_reset();
        e_ctl = '0; e_imm = '0; e_ra = '0; e_rb = '0; e_rc = '0;
        e_stall = '0; e_flush = '0;
    endtask

    task automatic set_idle();
        in_valid = 0; in_instr = '0; in_instr_id = '0; in_unit_id = '0; in_latency = '0;
        in_reg_wr = 0; in_reg_dst = '0; in_imme7 = '0; in_imme10 = '0; in_imme16 = '0;
        in_imme18 = '0; in_pc = '0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
        in_ra_use = 0; in_rb_use = 0; in_rc_use = 0;
        rf_ra_data = '0; rf_rb_data = '0; rf_rc_data = '0;
        wb_addr = '0; wb_data = '0; wb_en = 0; flush = 0;
        for (int k = 0; k < 8; k++) begin
            f_wr[k] = 0; f_dst[k] = '0; f_lat[k] = '0; f_res[k] = '0; f_unit[k] = '0;
        end
    endtask

    task automatic set_random();
        in_valid    = ($urandom_range(0, 9) < 8);
        in_instr    = $urandom;
        in_instr_id = 7'($urandom);
        in_unit_id  = 3'($urandom_range(5, 7));
        in_latency  = 4'($urandom_range(0, 8));
        in_reg_wr   = 1'($urandom);
        in_reg_dst  = 7'($urandom_range(0, 7));
        in_imme7 = 7'($urandom); in_imme10 = 10'($urandom); in_imme16 = 16'($urandom);
        in_imme18 = 18'($urandom); in_pc = 10'($urandom);
        in_ra_addr = 7'($urandom_range(0, 7));
        in_rb_addr = 7'($urandom_range(0, 7));
        in_rc_addr = 7'($urandom_range(0, 7));
        in_ra_use = 1'($urandom); in_rb_use = 1'($urandom); in_rc_use = 1'($urandom);
        rf_ra_data = rnd128(); rf_rb_data = rnd128(); rf_rc_data = rnd128();
        wb_en = 1'($urandom); wb_addr = 7'($urandom_range(0, 7)); wb_data = rnd128();
        flush = ($urandom_range(0, 9) == 0);
        for (int k = 2; k <= 7; k++) begin
            f_wr[k]   = ($urandom_range(0, 2) == 0);
            f_dst[k]  = 7'($urandom_range(0, 7));
            f_lat[k]  = 4'($urandom_range(0, 9));
            f_res[k]  = rnd128();
            f_unit[k] = 3'($urandom);
        end
    endtask

    // One clock: check in_ready for current inputs, then the registered result
    task automatic step(input string tag);
        logic         hza, hzb, hzc, hazard;
        logic [127:0] da, db, dc;
        bit           load;
        fwd_stage2 = mk_pack(2); fwd_stage3 = mk_pack(3); fwd_stage4 = mk_pack(4);
        fwd_stage5 = mk_pack(5); fwd_stage6 = mk_pack(6); fwd_stage7 = mk_pack(7);
        #1;
        model_src(in_ra_addr, in_ra_use, rf_ra_data, hza, da);
        model_src(in_rb_addr, in_rb_use, rf_rb_data, hzb, db);
        model_src(in_rc_addr, in_rc_use, rf_rc_data, hzc, dc);
        hazard = in_valid && (hza || hzb || hzc);
        check({tag, "_in_ready"}, 128'(in_ready), 128'(!hazard));
        load = in_valid && !hazard && !flush;
        @(posedge clk);
        #1;
        if (load) begin
            e_ctl = {in_instr, in_instr_id, in_unit_id, in_latency, in_reg_wr, in_reg_dst};
            e_imm = {in_imme7, in_imme10, in_imme16, in_imme18, in_pc};
            e_ra = da; e_rb = db; e_rc = dc;
        end else begin
            e_ctl = '0; e_imm = '0; e_ra = '0; e_rb = '0; e_rc = '0;
        end
        if (hazard && (e_stall != 32'hFFFF_FFFF)) e_stall = e_stall + 1;
        if (flush && (e_flush != 16'hFFFF)) e_flush = e_flush + 1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        #12;
        check_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain issue from the register file
        set_idle();
        in_valid = 1; in_ra_addr = 7'd5; in_ra_use = 1; rf_ra_data = {32{4'hA}};
        in_instr = 32'h1234_5678; in_unit_id = 3'b101;
        step("rf_issue");

        // Stage-1 producer of r9, then a reader of r9 stalls
        set_idle();
        in_valid = 1; in_reg_wr = 1; in_reg_dst = 7'd9; in_latency = 4'd2; in_unit_id = 3'b110;
        step("s1_prod");
        set_idle();
        in_valid = 1; in_rb_addr = 7'd9; in_rb_use = 1; in_instr = 32'hCAFE;
        step("s1_stall");

        // Stage 4, latency 3: forwardable
        set_idle();
        in_valid = 1; in_rb_addr = 7'd12; in_rb_use = 1;
        f_wr[4] = 1; f_dst[4] = 7'd12; f_lat[4] = 4'd3; f_res[4] = {32{4'h5}};
        step("fwd_s4");

        // Stage 3, latency 6: stall
        set_idle();
        in_valid = 1; in_rb_addr = 7'd12; in_rb_use = 1;
        f_wr[3] = 1; f_dst[3] = 7'd12; f_lat[3] = 4'd6;
        step("stall_s3");

        // Youngest of stage 2 and stage 6 wins
        set_idle();
        in_valid = 1; in_rc_addr = 7'd3; in_rc_use = 1;
        f_wr[2] = 1; f_dst[2] = 7'd3; f_lat[2] = 4'd1; f_res[2] = {4{32'h1111_2222}};
        f_wr[6] = 1; f_dst[6] = 7'd3; f_lat[6] = 4'd9; f_res[6] = {4{32'h3333_4444}};
        step("youngest");

        // Write-back port beats stale register file, address 0 ordinary
        set_idle();
        in_valid = 1; in_ra_addr = 7'd7; in_ra_use = 1; rf_ra_data = 128'h1;
        in_rb_addr = 7'd0; in_rb_use = 1; rf_rb_data = 128'h77;
        wb_en = 1; wb_addr = 7'd7; wb_data = {32{4'hF}};
        step("wb_sel");

        // Flush with a clean transfer yields a bubble
        set_idle();
        in_valid = 1; in_reg_wr = 1; in_reg_dst = 7'd4; in_unit_id = 3'b111; flush = 1;
        step("flush");

        // Three stall cycles from a held stage-3 producer
        set_idle();
        in_valid = 1; in_ra_addr = 7'd2; in_ra_use = 1;
        f_wr[3] = 1; f_dst[3] = 7'd2; f_lat[3] = 4'd5;
        for (int i = 0; i < 3; i++) step("stall3");

        // Reset during a stage-1 stall clears outputs at once
        set_idle();
        in_valid = 1; in_reg_wr = 1; in_reg_dst = 7'd9; in_instr = 32'hABCD;
        step("pre_rst");
        set_idle();
        in_valid = 1; in_ra_addr = 7'd9; in_ra_use = 1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_rst");
        check("mid_rst_ready", 128'(in_ready), 128'(1'b1));
        #1;
        rst = 1'b0;
        step("post_rst");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_random();
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/odd_issue_stage.md
Name: odd_issue_stage

Overview:
- Register-fetch/issue stage directly upstream of the odd pipe (permute, load/store, branch).
- Accepts one decoded odd instruction per cycle and selects each source operand from forwarding or the register file.
- Stalls decode on RAW hazards against results still in flight, and drives the odd pipe's input register with either the instruction or a bubble.

Parameters:
- DATA_W, 128, register/operand width.
- RADDR_W, 7, register address width.
- PACK_W, 143, packed stage word: [0:2] unit_id, [3:130] result, [131:137] reg_dst, [138:141] latency, [142] reg_wr.

Ports:
- clk input 1: clock.
- rst input 1: reset, asynchronous, active-high.
- in_valid input 1: decode presents an instruction.
- in_ready output 1: stage accepts this cycle; combinational = !hazard.
- in_instr, in_instr_id, in_unit_id, in_latency, in_reg_wr, in_reg_dst input 32/7/3/4/1/7: decoded fields.
- in_imme7, in_imme10, in_imme16, in_imme18, in_pc input 7/10/16/18/10: immediates and PC.
- in_ra_addr, in_rb_addr, in_rc_addr input 7 each: source addresses.
- in_ra_use, in_rb_use, in_rc_use input 1 each: source actually read.
- rf_ra_data, rf_rb_data, rf_rc_data input 128 each: register file read data for the current addresses.
- fwd_stage2 … fwd_stage7 input PACK_W each: odd-pipe packed stages 2..7.
- wb_addr, wb_data, wb_en input 7/128/1: write-back port.
- flush input 1: taken branch, kill the held instruction.
- out_instr … out_pc, out_ra_data, out_rb_data, out_rc_data output: registered copies of all fields and resolved operands, same widths as the inputs.

Behaviour:
- Reset: all outputs 0, including unit_id 0 and reg_wr 0 (bubble).
- Output register is the odd pipe's stage-1 instruction.
- Each cycle, the output register loads exactly one of: the accepted instruction, or a bubble (all fields 0).

In-flight producers (per used source):
- Stage-1 producer: the current output register; hazard whenever its reg_wr=1 and reg_dst matches.
- Stage k (2..7) producer: fwd_stagek with reg_wr=1 and reg_dst matching.
- A stage-k producer is forwardable iff k > latency; otherwise it is a hazard.

Hazard and handshake:
- hazard = in_valid && any used source has its youngest matching producer not forwardable.
- Only the youngest match is considered; older stages are ignored.
- in_ready = !hazard.
- Transfer occurs when in_valid && in_ready.

Operand select, per source, youngest first:
- stage 1 (hazard only, never forwarded);
- stages 2..7, forwarding result [3:130];
- WB port when wb_en and wb_addr match;
- rf data.

Issue and flush:
- Transfer without flush: load the instruction and operands.
- Otherwise: load a bubble.
- flush=1 forces a bubble the next cycle regardless of in_valid; in_ready is still driven by the hazard logic.
- Flush and transfer in the same cycle: the instruction is dropped and decode sees it as consumed.
- Unused sources are never hazards; their operand is still muxed.
- Latency 0 is treated as immediately forwardable.
- Address 0 is an ordinary register.
- Reset mid-stall: bubble, in_ready=1 after reset.

Optional Feature:
- Macro ODD_ISSUE_PERF_EN.
- When defined, adds output stall_count, 32-bit, and output flush_count, 16-bit.
- Both counters clear on rst and saturate at all-ones.
- stall_count increments on each cycle with in_valid && hazard.
- flush_count increments on each cycle with flush=1.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds the PACK_W field offsets (UNIT, RESULT, DST, LAT, WR), the bubble constant and the unit-id encodings 101/110/111.
- Sub-module odd_operand_sel, instantiated three times: one source address in, returns hazard and selected 128-bit data.

Test Plan:
1. No producers: ra=5, rf=0xA… → out_ra_data=0xA…, issued next cycle, in_ready=1 throughout.
2. Stage-1 reg_dst=9 reg_wr=1, next instr reads r9 → in_ready=0, bubble issued.
3. fwd_stage4 dst=12 lat=3 result=0x55… and rf r12=0 → out_rb_data=0x55… (4>3).
4. fwd_stage3 dst=12 lat=6 → stall.
5. Youngest wins: fwd_stage2 and fwd_stage6 both dst=3, stage2 lat=1 result=X, stage6 result=Y → X selected. WB r7=0xF… with rf stale → WB value selected.
6. flush=1 with in_valid=1 and no hazard → next cycle output is bubble (unit 0, reg_wr 0), in_ready=1. Async rst asserted mid-stall → outputs 0 immediately; with ODD_ISSUE_PERF_EN, 3 stall cycles → stall_count=3.
